// File: rtl/lowampa_capture_pkg.sv
// Shared types and constants for the low-amplitude trigger debug-capture sequencer.
package lowampa_capture_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRE       = 3'd1,
    WAIT_TRIG = 3'd2,
    POST      = 3'd3,
    STOP      = 3'd4,
    READOUT   = 3'd5,
    HOLD      = 3'd6
  } state_e;

  localparam logic [15:0] DEF_PRETRIG_LEN  = 16'd10;
  localparam logic [15:0] DEF_POSTTRIG_LEN = 16'd5;
  localparam logic [15:0] DEF_HOLDOFF_LEN  = 16'd4;

  localparam logic [15:0] MISSED_MAX = 16'hFFFF;

endpackage

// File: rtl/lowampa_sat_counter.sv
// Event counter that either wraps or sticks at all-ones.
module lowampa_sat_counter #(
  parameter int WIDTH    = 16,
  parameter bit SATURATE = 1'b1
) (
  input  logic             aclk,
  input  logic             reset_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge aclk) begin
    if (reset_i) begin
      count_q <= '0;
    end else if (inc_i && !(SATURATE && (&count_q))) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/lowampa_capture_sequencer.sv
// Arms the capture buffers, enforces pre-trigger fill, accepts one trigger,
// records the post-trigger window and waits for readout before re-arming.
// states: IDLE 0 | PRE 1 fill | WAIT_TRIG 2 | POST 3 | STOP 4 frame align | READOUT 5 | HOLD 6
module lowampa_capture_sequencer
  import lowampa_capture_pkg::*;
#(
  parameter int NBEAMS    = 2,
  parameter int CNT_BITS  = 16,
  parameter int TCNT_BITS = 32
) (
  input  logic                 aclk,
  input  logic                 reset_i,
  input  logic                 aclk_phase_i,
  input  logic                 run_i,
  input  logic                 sw_trig_i,
  input  logic [NBEAMS-1:0]    trig_i,
  input  logic [NBEAMS-1:0]    trig_mask_i,
  input  logic [CNT_BITS-1:0]  pretrig_len_i,
  input  logic [CNT_BITS-1:0]  posttrig_len_i,
  input  logic [CNT_BITS-1:0]  holdoff_len_i,
  input  logic                 capture_waiting_i,
  output logic                 capture_enable_o,
  output logic                 trigger_o,
  output logic [NBEAMS:0]      trig_source_o,
  output logic [TCNT_BITS-1:0] trig_count_o,
  output logic [15:0]          missed_count_o,
  output logic [2:0]           state_o
);

  localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);

  state_e              state_q;
  logic [CNT_BITS-1:0] cnt_q;
  logic                seen_wait_q;
  logic                hit_q;
  logic                cap_en_q;
  logic                trigger_q;
  logic [NBEAMS:0]     src_q;

  logic [NBEAMS-1:0] beam_hits;
  logic              hit;
  logic              accept;
  logic              miss_inc;

  assign beam_hits = trig_i & trig_mask_i;
  assign hit       = (|beam_hits) | sw_trig_i;
  assign accept    = (state_q == WAIT_TRIG) && run_i && hit;
  // level triggers count once, on the rising edge of hit
  assign miss_inc  = (state_q != WAIT_TRIG) && hit && !hit_q;

  always_ff @(posedge aclk) begin
    if (reset_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      seen_wait_q <= 1'b0;
      hit_q       <= 1'b0;
      cap_en_q    <= 1'b0;
      trigger_q   <= 1'b0;
      src_q       <= '0;
    end else begin
      hit_q     <= hit;
      trigger_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (run_i && aclk_phase_i) begin
            cap_en_q <= 1'b1;
            if (pretrig_len_i != '0) begin
              state_q <= PRE;
              cnt_q   <= pretrig_len_i - CNT_ONE;
            end else begin
              state_q <= WAIT_TRIG;
            end
          end
        end
        PRE: begin
          if (!run_i) begin
            state_q  <= IDLE;
            cap_en_q <= 1'b0;
          end else if (cnt_q == '0) begin
            state_q <= WAIT_TRIG;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        WAIT_TRIG: begin
          if (!run_i) begin
            state_q  <= IDLE;
            cap_en_q <= 1'b0;
          end else if (hit) begin
            trigger_q <= 1'b1;
            src_q     <= {sw_trig_i, beam_hits};
            if (posttrig_len_i != '0) begin
              state_q <= POST;
              cnt_q   <= posttrig_len_i - CNT_ONE;
            end else begin
              state_q  <= STOP;
              cap_en_q <= 1'b0;
            end
          end
        end
        POST: begin
          if (!run_i) begin
            state_q  <= IDLE;
            cap_en_q <= 1'b0;
          end else if (cnt_q == '0) begin
            state_q  <= STOP;
            cap_en_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        STOP: begin
          if (aclk_phase_i) begin
            state_q     <= READOUT;
            seen_wait_q <= 1'b0;
          end
        end
        READOUT: begin
          if (capture_waiting_i) begin
            seen_wait_q <= 1'b1;
          end else if (seen_wait_q) begin
            state_q <= HOLD;
            cnt_q   <= holdoff_len_i;
          end
        end
        HOLD: begin
          // dead time is holdoff_len cycles, at least one
          if (cnt_q == '0 || cnt_q == CNT_ONE) begin
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        default: begin
          state_q  <= IDLE;
          cap_en_q <= 1'b0;
        end
      endcase
    end
  end

  lowampa_sat_counter #(
    .WIDTH    (TCNT_BITS),
    .SATURATE (1'b0)
  ) u_trig_cnt (
    .aclk    (aclk),
    .reset_i (reset_i),
    .inc_i   (accept),
    .count_o (trig_count_o)
  );

  lowampa_sat_counter #(
    .WIDTH    (16),
    .SATURATE (1'b1)
  ) u_missed_cnt (
    .aclk    (aclk),
    .reset_i (reset_i),
    .inc_i   (miss_inc),
    .count_o (missed_count_o)
  );

  assign capture_enable_o = cap_en_q;
  assign trigger_o        = trigger_q;
  assign trig_source_o    = src_q;
  assign state_o          = state_q;

endmodule
